// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: step-mode encoding and
// burst controller state.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_SHR = 2'b00,
    MODE_SHL = 2'b01,
    MODE_ROR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: accepts Load/Start in IDLE, clamps the step count to the
// register width, and sequences one step per cycle while in SHIFT.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             load_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             load_en_o,
  output logic             step_en_o,
  output logic [1:0]       mode_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] steps_d;

  assign steps_d = (count_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count_i;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_SHR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Load has priority over Start in the same cycle.
          if (!load_i && start_i) begin
            if (steps_d != '0) begin
              state_q <= ST_SHIFT;
              cnt_q   <= steps_d;
              mode_q  <= mode_i;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load_en_o = (state_q == ST_IDLE) && load_i;
  assign step_en_o = (state_q == ST_SHIFT);
  assign mode_o    = mode_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load and counted shift bursts.
// Define USR_ROTATE_EN to enable the rotate modes (Mode 10/11).
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Count,
  input  logic             SinR,
  input  logic             SinL,
  output logic [WIDTH-1:0] Dout,
  output logic             SoutR,
  output logic             SoutL,
  output logic             Busy,
  output logic             Done
);

  logic             load_en;
  logic             step_en;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] step_val;

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk_i     (Clk),
    .nreset_i  (nReset),
    .load_i    (Load),
    .start_i   (Start),
    .mode_i    (Mode),
    .count_i   (Count),
    .load_en_o (load_en),
    .step_en_o (step_en),
    .mode_o    (mode_q),
    .busy_o    (Busy),
    .done_o    (Done)
  );

`ifdef USR_ROTATE_EN
  always_comb begin
    step_val = {SinR, shreg_q[WIDTH-1:1]};
    case (mode_e'(mode_q))
      MODE_SHR: step_val = {SinR, shreg_q[WIDTH-1:1]};
      MODE_SHL: step_val = {shreg_q[WIDTH-2:0], SinL};
      MODE_ROR: step_val = {shreg_q[0], shreg_q[WIDTH-1:1]};
      MODE_ROL: step_val = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      default:  step_val = {SinR, shreg_q[WIDTH-1:1]};
    endcase
  end
`else
  // Without rotate support only the direction bit matters.
  logic unused_mode_hi;
  assign unused_mode_hi = mode_q[1];
  assign step_val = mode_q[0] ? {shreg_q[WIDTH-2:0], SinL}
                              : {SinR, shreg_q[WIDTH-1:1]};
`endif

  always_comb begin
    shreg_d = shreg_q;
    if (load_en)      shreg_d = Din;
    else if (step_en) shreg_d = step_val;
  end

  always_ff @(posedge Clk) begin
    if (!nReset) shreg_q <= '0;
    else         shreg_q <= shreg_d;
  end

  assign Dout  = shreg_q;
  assign SoutR = shreg_q[0];
  assign SoutL = shreg_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8): directed scenarios plus random
// bursts checked against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          Clk = 1'b0;
  logic          nReset, Load, Start, SinR, SinL;
  logic [W-1:0]  Din;
  logic [1:0]    Mode;
  logic [CW-1:0] Count;
  logic [W-1:0]  Dout;
  logic          SoutR, SoutL, Busy, Done;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mdl;

  always #5 Clk = ~Clk;

  universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .nReset(nReset), .Load(Load), .Din(Din), .Start(Start),
    .Mode(Mode), .Count(Count), .SinR(SinR), .SinL(SinL), .Dout(Dout),
    .SoutR(SoutR), .SoutL(SoutL), .Busy(Busy), .Done(Done)
  );

  // One step of the register expressed as integer arithmetic.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] r, input logic [1:0] m,
                                            input logic sr, input logic sl);
    int v, o, md, top;
    v   = int'(r);
    md  = int'(m);
    top = 2 ** (W - 1);
`ifndef USR_ROTATE_EN
    md = md % 2;
`endif
    case (md)
      0:       o = (v / 2) + (sr ? top : 0);
      1:       o = ((v * 2) % (2 ** W)) + (sl ? 1 : 0);
      2:       o = (v / 2) + ((v % 2) * top);
      default: o = ((v * 2) % (2 ** W)) + (v / top);
    endcase
    return o[W-1:0];
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    @(negedge Clk);
    Load = 1'b1; Din = v; Start = 1'($urandom % 2); Count = 4'd3;
    @(posedge Clk); #1;
    Load = 1'b0; Start = 1'b0;
    mdl = v;
    checks++;
    if (Dout !== v || Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL load: Dout=%h Busy=%b Done=%b expected Dout=%h Busy=0 Done=0", Dout, Busy, Done, v);
    if (Dout !== v || Busy !== 1'b0 || Done !== 1'b0) errors++;
  endtask

  task automatic idle_cycle();
    @(negedge Clk);
    Load = 1'b0; Start = 1'b0; SinR = 1'($urandom % 2); SinL = 1'($urandom % 2);
    @(posedge Clk); #1;
    checks++;
    if (Dout !== mdl || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: Dout=%h Busy=%b Done=%b expected Dout=%h Busy=0 Done=0", Dout, Busy, Done, mdl);
    end
  endtask

  task automatic run_burst(input logic [1:0] m, input int cnt, input logic [15:0] srb,
                           input logic [15:0] slb, input bit noise);
    int n;
    n = (cnt > W) ? W : cnt;
    @(negedge Clk);
    Load = 1'b0; Start = 1'b1; Mode = m; Count = cnt[CW-1:0];
    @(posedge Clk); #1;
    Start = 1'b0;
    if (n == 0) begin
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b1 || Dout !== mdl) begin
        errors++;
        $display("FAIL zero_count: Busy=%b Done=%b Dout=%h expected Busy=0 Done=1 Dout=%h", Busy, Done, Dout, mdl);
      end
      return;
    end
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL burst_start: Busy=%b Done=%b expected Busy=1 Done=0", Busy, Done);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      SinR = srb[i]; SinL = slb[i];
      if (noise) begin
        Load = 1'($urandom % 2); Din = 8'h55; Start = 1'($urandom % 2);
        Mode = 2'($urandom); Count = CW'($urandom);
      end
      @(posedge Clk); #1;
      mdl = ref_step(mdl, m, srb[i], slb[i]);
      checks++;
      if (Dout !== mdl || SoutR !== mdl[0] || SoutL !== mdl[W-1]) begin
        errors++;
        $display("FAIL step%0d_data: Dout=%h SoutR=%b SoutL=%b expected Dout=%h", i, Dout, SoutR, SoutL, mdl);
      end
      checks++;
      if (Busy !== 1'(i < n - 1) || Done !== 1'(i == n - 1)) begin
        errors++;
        $display("FAIL step%0d_ctrl: Busy=%b Done=%b expected Busy=%b Done=%b", i, Busy, Done, i < n - 1, i == n - 1);
      end
    end
    Load = 1'b0; Start = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; Load = 1'b1; Din = 8'hFF; Start = 1'b1; Mode = 2'b00; Count = 4'd3;
    SinR = 1'b1; SinL = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (Dout !== 8'h00 || SoutR !== 1'b0 || SoutL !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: Dout=%h SoutR=%b SoutL=%b expected 00/0/0", Dout, SoutR, SoutL);
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: Busy=%b Done=%b expected 0/0", Busy, Done);
    end
    @(negedge Clk);
    nReset = 1'b1; Load = 1'b0; Start = 1'b0;
    mdl = '0;
    idle_cycle();
  endtask

  task automatic test_shift_right();
    do_load(8'hAA);
    run_burst(2'b00, 3, 16'hFFFF, 16'h0000, 1'b0);
    checks++;
    if (Dout !== 8'hF5) begin
      errors++;
      $display("FAIL shr_result: Dout=%h expected F5", Dout);
    end
    idle_cycle();
  endtask

  task automatic test_shift_left();
    do_load(8'h81);
    run_burst(2'b01, 2, 16'($urandom), 16'h0000, 1'b0);
    checks++;
    if (Dout !== 8'h04 || SoutL !== 1'b0) begin
      errors++;
      $display("FAIL shl_result: Dout=%h SoutL=%b expected 04/0", Dout, SoutL);
    end
  endtask

  task automatic test_rotate();
    logic [W-1:0] exp_v;
`ifdef USR_ROTATE_EN
    exp_v = 8'hC0;
`else
    exp_v = 8'h40;
`endif
    do_load(8'h81);
    run_burst(2'b10, 1, 16'h0000, 16'h0000, 1'b0);
    checks++;
    if (Dout !== exp_v) begin
      errors++;
      $display("FAIL rotate_result: Dout=%h expected %h", Dout, exp_v);
    end
  endtask

  task automatic test_count_bounds();
    do_load(8'h3C);
    run_burst(2'($urandom), 0, 16'hFFFF, 16'hFFFF, 1'b0);
    idle_cycle();
    do_load(8'h00);
    run_burst(2'b00, 12, 16'hFFFF, 16'h0000, 1'b0);
    checks++;
    if (Dout !== 8'hFF) begin
      errors++;
      $display("FAIL clamp_result: Dout=%h expected FF", Dout);
    end
    idle_cycle();
  endtask

  task automatic test_ignore_midburst();
    do_load(8'h0F);
    run_burst(2'b01, 5, 16'($urandom), 16'($urandom), 1'b1);
    idle_cycle();
  endtask

  task automatic test_reset_midburst();
    do_load(8'hC3);
    @(negedge Clk);
    Start = 1'b1; Mode = 2'b01; Count = 4'd5;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    nReset = 1'b0;
    @(posedge Clk); #1;
    mdl = '0;
    checks++;
    if (Dout !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midburst: Dout=%h Busy=%b Done=%b expected 00/0/0", Dout, Busy, Done);
    end
    @(negedge Clk);
    nReset = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (Dout !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_midburst: Dout=%h Busy=%b Done=%b expected 00/0/0", Dout, Busy, Done);
    end
  endtask

  task automatic test_back_to_back();
    do_load(8'($urandom));
    run_burst(2'($urandom), 3, 16'($urandom), 16'($urandom), 1'b0);
    run_burst(2'($urandom), 2, 16'($urandom), 16'($urandom), 1'b0);
    run_burst(2'($urandom), 0, 16'($urandom), 16'($urandom), 1'b0);
    run_burst(2'($urandom), 4, 16'($urandom), 16'($urandom), 1'b1);
    idle_cycle();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      case ($urandom % 4)
        0:       do_load(8'($urandom));
        1:       idle_cycle();
        default: run_burst(2'($urandom), int'($urandom % 16), 16'($urandom),
                           16'($urandom), 1'($urandom % 2));
      endcase
    end
    idle_cycle();
  endtask

  initial begin
    Load = 1'b0; Start = 1'b0; Din = '0; Mode = '0; Count = '0;
    SinR = 1'b0; SinL = 1'b0; nReset = 1'b0; mdl = '0;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_rotate();
    test_count_bounds();
    test_ignore_midburst();
    test_reset_midburst();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal range ≥ 2.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of Count.
REQ-003 Clk  in  1  clock; all state updates on rising edge.
REQ-004 nReset  in  1  reset, synchronous, active-low.
REQ-005 Load  in  1  parallel-load strobe.
REQ-006 Din  in  WIDTH  parallel load data.
REQ-007 Start  in  1  burst-start strobe.
REQ-008 Mode  in  2  00 shift right, 01 shift left, 10 rotate right, 11 rotate left.
REQ-009 Count  in  CNT_W  number of single-bit steps in the burst.
REQ-010 SinR  in  1  serial input entering the MSB on right shift.
REQ-011 SinL  in  1  serial input entering the LSB on left shift.
REQ-012 Dout  out  WIDTH  register contents.
REQ-013 SoutR  out  1  register bit 0.
REQ-014 SoutL  out  1  register bit WIDTH-1.
REQ-015 Busy  out  1  high while a burst is in progress.
REQ-016 Done  out  1  one-cycle pulse marking burst completion.

Function
REQ-017 The FSM SHALL have two states, IDLE and SHIFT.
REQ-018 In IDLE with Load=1, the register SHALL take Din at the edge; Start is ignored in that cycle.
REQ-019 In IDLE with Load=0, Start=1 and Count=N>0, the block SHALL latch Mode and min(N,WIDTH) and enter SHIFT; Busy is high from the next cycle.
REQ-020 In SHIFT, each edge SHALL perform one step per the latched Mode and decrement the remaining count.
REQ-021 Shift right SHALL be {SinR, reg[WIDTH-1:1]}; shift left SHALL be {reg[WIDTH-2:0], SinL}.
REQ-022 SinR and SinL SHALL be sampled live at each step edge, not latched at Start.
REQ-023 The burst SHALL take N steps at edges k+1..k+N after Start is sampled at edge k; after edge k+N, state is IDLE, Busy=0 and Done=1 for exactly one cycle.
REQ-024 Start with Count=0 SHALL leave the register unchanged, keep Busy=0, and pulse Done in the cycle after edge k.
REQ-025 Count>WIDTH SHALL clamp to WIDTH steps.
REQ-026 Load and Start asserted while Busy=1 SHALL be ignored; Mode and Count changes during a burst have no effect.
REQ-027 Start may be sampled in the same cycle Done is high; a new burst then begins normally.
REQ-028 With Load=0 and Start=0 in IDLE, the register SHALL hold.

Reset
REQ-029 nReset=0 at an edge SHALL force the register to 0, the state to IDLE, and Busy, Done and the step counter to 0, overriding all other inputs, including mid-burst.
REQ-030 Out of reset: Dout=0, SoutR=0, SoutL=0, Busy=0, Done=0.

Configuration
REQ-031 Macro USR_ROTATE_EN defined: Mode 10 SHALL rotate right as {reg[0], reg[WIDTH-1:1]}; Mode 11 SHALL rotate left as {reg[WIDTH-2:0], reg[WIDTH-1]}.
REQ-032 Macro USR_ROTATE_EN undefined: Mode[1] SHALL be ignored, so Mode 10 acts as 00 and Mode 11 acts as 01, and no rotate logic is generated.

Structure
REQ-033 Package usr_pkg SHALL hold the Mode encoding enum and the FSM state enum.
REQ-034 Sub-module usr_burst_ctrl SHALL contain the FSM, the clamp logic, the down-counter, Busy and Done; the top SHALL contain the datapath register and step mux.

Verification (WIDTH=8)
REQ-035 Reset: nReset=0 for 2 cycles with Load=1 and Din=FF -> Dout=00, Busy=0, Done=0.
REQ-036 Load AA; Start with Mode=00, Count=3, SinR=1 -> Busy high for 3 cycles, Dout=F5, one-cycle Done.
REQ-037 Load 81; Start with Mode=01, Count=2, SinL=0 -> Dout=04, SoutL=0.
REQ-038 Load 81; Mode=10, Count=1, SinR=0 -> Dout=C0 with USR_ROTATE_EN, Dout=40 without.
REQ-039 Start with Count=0 -> Dout unchanged, Busy stays 0, Done pulses; Start with Count=12 -> exactly 8 steps.
REQ-040 Load 55 asserted mid-burst is ignored; nReset=0 mid-burst -> Dout=00, Busy=0 next cycle, and no Done pulse.
